// File: rtl/framebuffer_exporter.sv
// framebuffer_exporter: streams RGB565 framebuffer pixels out as RGB888 bytes over valid/ready.
// Optional BGR_ORDER_EN macro switches the byte order to B,G,R (BMP order).
module framebuffer_exporter #(
  parameter int NUM_PIXELS = 76800,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [15:0]       fb_data,
  output logic [7:0]        byte_data,
  output logic              byte_valid,
  input  logic              byte_ready
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND0, SEND1, SEND2, DONE} state_t;
`ifdef BGR_ORDER_EN
  localparam bit BGR = 1'b1;
`else
  localparam bit BGR = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIXELS - 1);
  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       pix;
  logic              acc;
  assign acc = byte_valid && byte_ready;
  function automatic logic [7:0] r8(input logic [15:0] p);
    return {p[15:11], p[15:13]};
  endfunction
  function automatic logic [7:0] g8(input logic [15:0] p);
    return {p[10:5], p[10:9]};
  endfunction
  function automatic logic [7:0] b8(input logic [15:0] p);
    return {p[4:0], p[4:2]};
  endfunction
  // byte_data is loaded one state ahead so every output stays registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      pix        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fb_rd_en   <= 1'b0;
      fb_addr    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          idx      <= '0;
          busy     <= 1'b1;
          fb_rd_en <= 1'b1;
          fb_addr  <= '0;
          state    <= FETCH;
        end
        FETCH: begin
          fb_rd_en <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          pix        <= fb_data;
          byte_data  <= BGR ? b8(fb_data) : r8(fb_data);
          byte_valid <= 1'b1;
          state      <= SEND0;
        end
        SEND0: if (acc) begin
          byte_data <= g8(pix);
          state     <= SEND1;
        end
        SEND1: if (acc) begin
          byte_data <= BGR ? r8(pix) : b8(pix);
          state     <= SEND2;
        end
        SEND2: if (acc) begin
          byte_valid <= 1'b0;
          if (idx == LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx      <= idx + 1'b1;
            fb_addr  <= idx + 1'b1;
            fb_rd_en <= 1'b1;
            state    <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
